// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter for the regfile write port, with a
// sequencer that zeroes registers 1..NUM_REGS-1 after reset and on request.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  Clk,
  input  logic                  ResetN,
  input  logic                  ValidA,
  input  logic [ADDR_WIDTH-1:0] AddrA,
  input  logic [DATA_WIDTH-1:0] DataA,
  output logic                  ReadyA,
  input  logic                  ValidB,
  input  logic [ADDR_WIDTH-1:0] AddrB,
  input  logic [DATA_WIDTH-1:0] DataB,
  output logic                  ReadyB,
  input  logic                  ClearReq,
  output logic                  Busy,
  output logic                  ClearDone,
  output logic [ADDR_WIDTH-1:0] WriteRegister,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  RegWrite
);
  typedef enum logic {INIT, RUN} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d, wreg_q, wreg_d, acc_addr;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic last_b_q, last_b_d, rw_q, rw_d, done_q, done_d;
  logic open, last_clr;
  // ClearReq blocks grants in its own cycle so nothing is accepted while the clear is entered
  assign open      = state_q == RUN && !ClearReq;
  assign ReadyA    = open && ValidA && (!ValidB || last_b_q);
  assign ReadyB    = open && ValidB && (!ValidA || !last_b_q);
  assign last_clr  = clr_cnt_q == ADDR_WIDTH'(NUM_REGS - 1);
  assign acc_addr  = ReadyA ? AddrA : AddrB;
  assign Busy          = state_q == INIT;
  assign ClearDone     = done_q;
  assign WriteRegister = wreg_q;
  assign WriteData     = wdata_q;
  assign RegWrite      = rw_q;
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    wreg_d    = wreg_q;
    wdata_d   = wdata_q;
    last_b_d  = last_b_q;
    rw_d      = 1'b0;
    done_d    = 1'b0;
    if (state_q == INIT) begin
      rw_d      = 1'b1;
      wreg_d    = clr_cnt_q;
      wdata_d   = '0;
      clr_cnt_d = last_clr ? ADDR_WIDTH'(1) : clr_cnt_q + 1'b1;
      state_d   = last_clr ? RUN : INIT;
      done_d    = last_clr;
    end else if (ClearReq) begin
      state_d = INIT;
    end else if (ReadyA || ReadyB) begin
      wreg_d   = acc_addr;
      wdata_d  = ReadyA ? DataA : DataB;
      rw_d     = acc_addr != '0;
      last_b_d = ReadyB;
    end
  end
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q   <= INIT;
      clr_cnt_q <= ADDR_WIDTH'(1);
      wreg_q    <= '0;
      wdata_q   <= '0;
      last_b_q  <= 1'b1;
      rw_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      wreg_q    <= wreg_d;
      wdata_q   <= wdata_d;
      last_b_q  <= last_b_d;
      rw_q      <= rw_d;
      done_q    <= done_d;
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed and random stimulus against a cycle-level
// reference model of the arbiter/clear behaviour.
module tb_regfile_write_arbiter;
  logic Clk = 0, ResetN = 0, ValidA = 0, ValidB = 0, ClearReq = 0;
  logic [4:0] AddrA = 0, AddrB = 0;
  logic [31:0] DataA = 0, DataB = 0;
  logic ReadyA, ReadyB, Busy, ClearDone, RegWrite;
  logic [4:0] WriteRegister;
  logic [31:0] WriteData;

  regfile_write_arbiter dut (
    .Clk(Clk), .ResetN(ResetN),
    .ValidA(ValidA), .AddrA(AddrA), .DataA(DataA), .ReadyA(ReadyA),
    .ValidB(ValidB), .AddrB(AddrB), .DataB(DataB), .ReadyB(ReadyB),
    .ClearReq(ClearReq), .Busy(Busy), .ClearDone(ClearDone),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite)
  );

  always #5 Clk = ~Clk;

  int tests = 0, fails = 0;
  bit m_busy, m_last_b, e_rw, e_cd, acc_a, acc_b, dut_ra, dut_rb;
  int m_next;
  logic [4:0] e_wr;
  logic [31:0] e_wd;
  string grants;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1; m_next = 1; m_last_b = 1;
    e_rw = 0; e_cd = 0; e_wr = 0; e_wd = 0;
  endtask

  // One clock: check readies before the edge, advance the model, check registered outputs after.
  task automatic step();
    bit ra, rb;
    #1;
    ra = !m_busy && !ClearReq && ValidA && (!ValidB || m_last_b);
    rb = !m_busy && !ClearReq && ValidB && (!ValidA || !m_last_b);
    check("ReadyA", ReadyA, ra);
    check("ReadyB", ReadyB, rb);
    check("ready_exclusive", ReadyA & ReadyB, 0);
    acc_a = ra; acc_b = rb;
    dut_ra = ValidA && ReadyA; dut_rb = ValidB && ReadyB;
    @(posedge Clk);
    e_cd = 0;
    if (m_busy) begin
      e_rw = 1; e_wr = 5'(m_next); e_wd = 0; e_cd = (m_next == 31);
      if (m_next == 31) begin m_busy = 0; m_next = 1; end else m_next++;
    end else begin
      e_rw = 0;
      if (ClearReq) m_busy = 1;
      else if (ra || rb) begin
        e_wr = ra ? AddrA : AddrB;
        e_wd = ra ? DataA : DataB;
        e_rw = e_wr != 0;
        m_last_b = rb;
        grants = {grants, ra ? "A" : "B"};
      end
    end
    #1;
    check("RegWrite", RegWrite, e_rw);
    check("WriteRegister", WriteRegister, e_wr);
    check("WriteData", WriteData, e_wd);
    check("Busy", Busy, m_busy);
    check("ClearDone", ClearDone, e_cd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, issued_a, issued_b, got_a, got_b;
    issued_a = 0; issued_b = 0; got_a = 0; got_b = 0;
    model_reset();
    #2;
    check("rst_RegWrite", RegWrite, 0);
    check("rst_Busy", Busy, 1);
    check("rst_ClearDone", ClearDone, 0);
    check("rst_WriteRegister", WriteRegister, 0);
    check("rst_WriteData", WriteData, 0);
    @(posedge Clk); #1; ResetN = 1;
    repeat (31) step();
    check("clear_done_busy_low", Busy, 0);
    ValidA = 1; AddrA = 2; DataA = 42;
    step();
    ValidA = 0;
    check("a_commit_reg", WriteRegister, 2);
    check("a_commit_data", WriteData, 42);
    step();
    // LastGrant is A after the reg-2 write, so contention starts with B
    grants = "";
    ValidA = 1; AddrA = 3; DataA = 34; ValidB = 1; AddrB = 4; DataB = 9;
    repeat (4) begin
      step();
      if (acc_a) DataA = $urandom;
      if (acc_b) DataB = $urandom;
    end
    ValidA = 0; ValidB = 0;
    tests++;
    assert (grants == "BABA") else begin
      fails++;
      $error("FAIL grant_order: got %s expected BABA", grants);
    end
    step();
    ValidB = 1; AddrB = 0; DataB = 25;
    step();
    ValidB = 0;
    check("reg0_accepted", dut_rb, 1);
    check("reg0_no_write", RegWrite, 0);
    ValidA = 1; AddrA = 5; DataA = 15;
    step();
    AddrA = 6; DataA = 77; ClearReq = 1;
    step();
    ClearReq = 0;
    check("clearreq_blocks_a", dut_ra, 0);
    n = 0;
    do begin step(); n++; end while (!dut_ra && n < 40);
    check("a_accept_after_clear", dut_ra, 1);
    check("clear_wait_cycles", n, 32);
    ValidA = 0;
    step();
    ClearReq = 1;
    step();
    ClearReq = 0;
    repeat (10) step();
    ResetN = 0;
    #1;
    check("async_rst_RegWrite", RegWrite, 0);
    check("async_rst_Busy", Busy, 1);
    check("async_rst_WriteRegister", WriteRegister, 0);
    model_reset();
    #1 ResetN = 1;
    step();
    check("restart_reg1", WriteRegister, 1);
    repeat (30) step();
    for (int i = 0; i < 400; i++) begin
      if (!ValidA && $urandom_range(2) == 0) begin
        ValidA = 1; AddrA = 5'($urandom); DataA = $urandom; issued_a++;
      end
      if (!ValidB && $urandom_range(2) == 0) begin
        ValidB = 1; AddrB = 5'($urandom); DataB = $urandom; issued_b++;
      end
      ClearReq = $urandom_range(49) == 0;
      step();
      ClearReq = 0;
      if (dut_ra) got_a++;
      if (dut_rb) got_b++;
      if (acc_a) ValidA = 0;
      if (acc_b) ValidB = 0;
    end
    for (int i = 0; i < 100 && (ValidA || ValidB); i++) begin
      step();
      if (dut_ra) got_a++;
      if (dut_rb) got_b++;
      if (acc_a) ValidA = 0;
      if (acc_b) ValidB = 0;
    end
    check("drain_a", got_a, issued_a);
    check("drain_b", got_b, issued_b);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
